// File: rtl/seven_segment_games.sv
// Four button-driven mini-games (counter, dice, higher/lower, binary quiz) on one 7-segment digit.
// Buttons are synchronised, debounced and turned into one-cycle press pulses.
module seven_segment_games #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [6:0]  SEG_DASH = 7'h40;

    logic [1:0]       sync1, sync2, deb, deb_d, pulse;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [3:0]       rand10;
    logic [2:0]       rand6;

    logic [3:0] cnt_digit, cnt_digit_n;
    logic [2:0] dice_val, dice_val_n;
    logic [3:0] hl_cur, hl_cur_n, hl_score, hl_score_n;
    logic       hl_ok, hl_ok_n, hl_bad, hl_bad_n;
    logic [3:0] qz_t, qz_t_n, qz_score, qz_score_n;
    logic       qz_ok, qz_ok_n, qz_bad, qz_bad_n;
    logic [7:0] uo_out_n, uio_out_n;

    logic       press_a, press_b, hl_win;
    logic [1:0] sel;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

    assign uio_oe  = 8'hFF;
    assign sel     = ui_in[3:2];
    assign press_a = pulse[0] & ~pulse[1];
    assign press_b = pulse[1] & ~pulse[0];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        sat_inc = (s == 4'hF) ? s : s + 4'd1;
    endfunction

    // Button path: 2-FF sync, stability counter, rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_d   <= '0;
            pulse   <= '0;
            deb_cnt <= '{default: '0};
        end else begin
            sync1 <= ui_in[1:0];
            sync2 <= sync1;
            deb_d <= deb;
            pulse <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Next game state; only the selected game reacts to a press
    always_comb begin
        cnt_digit_n = cnt_digit;
        dice_val_n  = dice_val;
        hl_cur_n    = hl_cur;
        hl_score_n  = hl_score;
        hl_ok_n     = hl_ok;
        hl_bad_n    = hl_bad;
        qz_t_n      = qz_t;
        qz_score_n  = qz_score;
        qz_ok_n     = qz_ok;
        qz_bad_n    = qz_bad;
        hl_win      = (press_a && rand10 > hl_cur) || (press_b && rand10 < hl_cur);

        case (sel)
            2'b00: begin
                if (press_a) cnt_digit_n = (cnt_digit == 4'd9) ? 4'd0 : cnt_digit + 4'd1;
                if (press_b) cnt_digit_n = (cnt_digit == 4'd0) ? 4'd9 : cnt_digit - 4'd1;
            end
            2'b01: begin
                if (press_a) dice_val_n = rand6 + 3'd1;
                if (press_b) dice_val_n = 3'd0;
            end
            2'b10: begin
                if (press_a || press_b) begin
                    hl_cur_n   = rand10;
                    hl_ok_n    = hl_win;
                    hl_bad_n   = ~hl_win;
                    hl_score_n = hl_win ? sat_inc(hl_score) : 4'd0;
                end
            end
            default: begin
                if (press_a) begin
                    if (ui_in[7:4] == qz_t) begin
                        qz_score_n = sat_inc(qz_score);
                        qz_ok_n    = 1'b1;
                        qz_bad_n   = 1'b0;
                        qz_t_n     = rand10;
                    end else begin
                        qz_score_n = 4'd0;
                        qz_ok_n    = 1'b0;
                        qz_bad_n   = 1'b1;
                    end
                end
                if (press_b) begin
                    qz_t_n   = rand10;
                    qz_ok_n  = 1'b0;
                    qz_bad_n = 1'b0;
                end
            end
        endcase

        case (sel)
            2'b00:   uo_out_n = {1'b0, seg7(cnt_digit_n)};
            2'b01:   uo_out_n = {1'b0, (dice_val_n == 3'd0) ? SEG_DASH : seg7({1'b0, dice_val_n})};
            2'b10:   uo_out_n = {hl_ok_n, seg7(hl_cur_n)};
            default: uo_out_n = {qz_ok_n, seg7(qz_t_n)};
        endcase

        case (sel)
            2'b10:   uio_out_n = {hl_bad_n, hl_ok_n, sel, hl_score_n};
            2'b11:   uio_out_n = {qz_bad_n, qz_ok_n, sel, qz_score_n};
            default: uio_out_n = {2'b00, sel, 4'h0};
        endcase
    end

    // Random counters, game state and registered display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rand10    <= '0;
            rand6     <= '0;
            cnt_digit <= '0;
            dice_val  <= '0;
            hl_cur    <= '0;
            hl_score  <= '0;
            hl_ok     <= 1'b0;
            hl_bad    <= 1'b0;
            qz_t      <= '0;
            qz_score  <= '0;
            qz_ok     <= 1'b0;
            qz_bad    <= 1'b0;
            uo_out    <= 8'h3F;
            uio_out   <= 8'h00;
        end else begin
            rand10    <= (rand10 == 4'd9) ? 4'd0 : rand10 + 4'd1;
            rand6     <= (rand6 == 3'd5) ? 3'd0 : rand6 + 3'd1;
            cnt_digit <= cnt_digit_n;
            dice_val  <= dice_val_n;
            hl_cur    <= hl_cur_n;
            hl_score  <= hl_score_n;
            hl_ok     <= hl_ok_n;
            hl_bad    <= hl_bad_n;
            qz_t      <= qz_t_n;
            qz_score  <= qz_score_n;
            qz_ok     <= qz_ok_n;
            qz_bad    <= qz_bad_n;
            uo_out    <= uo_out_n;
            uio_out   <= uio_out_n;
        end
    end

endmodule

// File: tb/tb_seven_segment_games.sv
// Directed and randomised checks of seven_segment_games against a game-rule model.
// The random source is modelled as "clock edges since reset" modulo 10 / 6.
module tb_seven_segment_games;

    localparam int N = 4;

    logic       clk, rst, ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    seven_segment_games #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int n_cmp, n_bad;
    int m_cnt, m_dice, m_cur, m_hscore, m_t, m_qscore;
    bit m_hok, m_hbad, m_qok, m_qbad;

    task automatic model_reset();
        m_cnt = 0; m_dice = 0; m_cur = 0; m_hscore = 0; m_hok = 0; m_hbad = 0;
        m_t = 0; m_qscore = 0; m_qok = 0; m_qbad = 0;
    endtask

    function automatic logic [7:0] exp_uo(input logic [1:0] s);
        case (s)
            2'd0:    return seg_tab[m_cnt];
            2'd1:    return (m_dice == 0) ? 8'h40 : seg_tab[m_dice];
            2'd2:    return {m_hok, seg_tab[m_cur][6:0]};
            default: return {m_qok, seg_tab[m_t][6:0]};
        endcase
    endfunction

    function automatic logic [7:0] exp_uio(input logic [1:0] s);
        case (s)
            2'd2:    return {m_hbad, m_hok, s, 4'(m_hscore)};
            2'd3:    return {m_qbad, m_qok, s, 4'(m_qscore)};
            default: return {2'b00, s, 4'h0};
        endcase
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check8({tag, ".uo_out"}, uo_out, exp_uo(ui_in[3:2]));
        check8({tag, ".uio_out"}, uio_out, exp_uio(ui_in[3:2]));
        check8({tag, ".uio_oe"}, uio_oe, 8'hFF);
    endtask

    // Drive buttons from a negedge; k0 is the number of edges seen at that moment
    task automatic press(input bit a, input bit b, input int hold, output int k0);
        @(negedge clk);
        k0 = edge_cnt;
        ui_in[0] = a;
        ui_in[1] = b;
        repeat (hold) @(negedge clk);
        ui_in[1:0] = 2'b00;
        repeat (12) @(negedge clk);
    endtask

    // Random value seen by the game when a press starting after edge k0 is acted upon
    function automatic int r10(input int k0); return (k0 + N + 3) % 10; endfunction
    function automatic int r6(input int k0);  return (k0 + N + 3) % 6;  endfunction

    task automatic set_sel(input logic [1:0] s);
        @(negedge clk);
        ui_in[3:2] = s;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_random();
        repeat ($urandom_range(0, 9)) @(negedge clk);
    endtask

    task automatic hl_step(input bit a, input int k0);
        int  n;
        bit  win;
        n   = r10(k0);
        win = (a && n > m_cur) || (!a && n < m_cur);
        m_hok = win; m_hbad = !win;
        m_hscore = win ? ((m_hscore == 15) ? 15 : m_hscore + 1) : 0;
        m_cur = n;
    endtask

    task automatic qz_submit(input int sw, input int k0);
        if (sw == m_t) begin
            m_qscore = (m_qscore == 15) ? 15 : m_qscore + 1;
            m_qok = 1; m_qbad = 0; m_t = r10(k0);
        end else begin
            m_qscore = 0; m_qok = 0; m_qbad = 1;
        end
    endtask

    initial begin
        int k0, sw;
        bit a;
        n_cmp = 0; n_bad = 0;
        ena = 1'b1; uio_in = 8'h00; ui_in = 8'h00;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_all("reset_release");

        // Counter: three increments, then four decrements wrapping 0 -> 9
        for (int i = 0; i < 3; i++) begin
            press(1, 0, N + 4, k0);
            m_cnt = (m_cnt + 1) % 10;
            check_all("cnt_inc");
        end
        check8("cnt_is_3", uo_out, 8'h4F);
        for (int i = 0; i < 4; i++) begin
            press(0, 1, N + 4, k0);
            m_cnt = (m_cnt + 9) % 10;
            check_all("cnt_dec");
        end
        check8("cnt_wrap_9", uo_out, 8'h6F);

        press(1, 0, N - 2, k0);
        check_all("cnt_glitch");
        press(1, 0, 20, k0);
        m_cnt = (m_cnt + 1) % 10;
        check_all("cnt_long_hold");

        // Dice
        set_sel(2'b01);
        check_all("dice_dash");
        for (int i = 0; i < 4; i++) begin
            idle_random();
            press(1, 0, N + 4, k0);
            m_dice = r6(k0) + 1;
            check_all("dice_roll");
        end
        press(0, 1, N + 4, k0);
        m_dice = 0;
        check_all("dice_clear");

        // Binary quiz: directed correct answer, directed wrong answer, then random play
        set_sel(2'b11);
        check_all("quiz_start");
        ui_in[7:4] = 4'd0;
        press(1, 0, N + 4, k0);
        qz_submit(0, k0);
        check_all("quiz_correct");
        check8("quiz_correct_uio", uio_out, 8'h5F & 8'h71 | 8'h30);
        sw = (m_t == 5) ? 6 : 5;
        ui_in[7:4] = 4'(sw);
        press(1, 0, N + 4, k0);
        qz_submit(sw, k0);
        check_all("quiz_wrong");
        for (int i = 0; i < 8; i++) begin
            idle_random();
            if ($urandom_range(0, 3) == 0) begin
                press(0, 1, N + 4, k0);
                m_t = r10(k0); m_qok = 0; m_qbad = 0;
                check_all("quiz_skip");
            end else begin
                sw = ($urandom_range(0, 2) != 0) ? m_t : int'($urandom_range(0, 9));
                ui_in[7:4] = 4'(sw);
                press(1, 0, N + 4, k0);
                qz_submit(sw, k0);
                check_all("quiz_submit");
            end
        end

        // Higher/lower random play
        set_sel(2'b10);
        check_all("hl_start");
        for (int i = 0; i < 10; i++) begin
            idle_random();
            a = 1'($urandom_range(0, 1));
            press(a, !a, N + 4, k0);
            hl_step(a, k0);
            check_all("hl_guess");
        end
        press(1, 1, N + 4, k0);
        check_all("hl_both_ignored");

        // Unselected games kept their state
        set_sel(2'b00);
        check_all("cnt_held");
        set_sel(2'b11);
        check_all("quiz_held");

        // Asynchronous reset in the middle of a game
        set_sel(2'b10);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check8("midrst_uo", uo_out, 8'h3F);
        check8("midrst_uio", uio_out, 8'h00);
        @(negedge clk);
        ui_in[3:2] = 2'b00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all("post_reset");
        press(1, 0, N + 4, k0);
        m_cnt = 1;
        check_all("post_reset_inc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
